// File: rtl/outmf_pkg.sv
// Shared defaults, FSM state encoding and field helpers for the output-MF centre-of-gravity
// accumulator.
package outmf_pkg;

  localparam int unsigned DefDepth = 32;
  localparam int unsigned DefAddrW = 5;
  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefMuW   = 16;
  localparam int unsigned DefAccW  = 32;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // Keeps the low mu_w bits of a RAM word; callers narrow the result to their MuW.
  function automatic logic [63:0] mu_extract(input logic [63:0] word, input int unsigned mu_w);
    logic [63:0] mask;
    mask = (64'd1 << mu_w) - 64'd1;
    return word & mask;
  endfunction

endpackage

// File: rtl/outmf_cog_acc_mac.sv
// Latency-aligned multiply-accumulate for the CoG numerator/denominator.
// With OUTMF_MAX_EN defined it also tracks the first index holding the largest mu.
module outmf_mac
  import outmf_pkg::*;
#(
  parameter int unsigned AddrW = DefAddrW,
  parameter int unsigned MuW   = DefMuW,
  parameter int unsigned AccW  = DefAccW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [AddrW-1:0] idx_i,
  input  logic [MuW-1:0]   mu_i,
  output logic [AccW-1:0]  num_o,
  output logic [AccW-1:0]  den_o
`ifdef OUTMF_MAX_EN
  ,
  output logic [MuW-1:0]   max_mu_o,
  output logic [AddrW-1:0] max_idx_o
`endif
);

  localparam int unsigned ProdW = MuW + AddrW;

  logic [ProdW-1:0] prod;
  logic [AccW-1:0]  num_q, den_q;

  assign prod = ProdW'(mu_i) * ProdW'(idx_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q <= '0;
      den_q <= '0;
    end else if (clear_i) begin
      num_q <= '0;
      den_q <= '0;
    end else if (valid_i) begin
      num_q <= num_q + AccW'(prod);
      den_q <= den_q + AccW'(mu_i);
    end
  end

  assign num_o = num_q;
  assign den_o = den_q;

`ifdef OUTMF_MAX_EN
  logic [MuW-1:0]   max_mu_q;
  logic [AddrW-1:0] max_idx_q;

  // Strict compare so ties keep the lowest index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_mu_q  <= '0;
      max_idx_q <= '0;
    end else if (clear_i) begin
      max_mu_q  <= '0;
      max_idx_q <= '0;
    end else if (valid_i && (mu_i > max_mu_q)) begin
      max_mu_q  <= mu_i;
      max_idx_q <= idx_i;
    end
  end

  assign max_mu_o  = max_mu_q;
  assign max_idx_o = max_idx_q;
`endif

endmodule

// File: rtl/outmf_cog_acc.sv
// Sweeps the output-MF RAM through port B and presents the CoG numerator/denominator on a
// valid/ready interface. OUTMF_MAX_EN adds max_mu_o/max_idx_o for mean-of-max.
module outmf_cog_acc
  import outmf_pkg::*;
#(
  parameter int unsigned Depth = DefDepth,
  parameter int unsigned AddrW = DefAddrW,
  parameter int unsigned DataW = DefDataW,
  parameter int unsigned MuW   = DefMuW,
  parameter int unsigned AccW  = DefAccW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  output logic             busy_o,
  output logic             rd_en_o,
  output logic [AddrW-1:0] rd_addr_o,
  input  logic [DataW-1:0] rd_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [AccW-1:0]  num_o,
  output logic [AccW-1:0]  den_o,
  output logic             den_zero_o
`ifdef OUTMF_MAX_EN
  ,
  output logic [MuW-1:0]   max_mu_o,
  output logic [AddrW-1:0] max_idx_o
`endif
);

  if (AccW < MuW + 2 * AddrW) begin : g_acc_w_check
    $error("outmf_cog_acc: AccW must be at least MuW + 2*AddrW");
  end
  if (Depth < 2) begin : g_depth_check
    $error("outmf_cog_acc: Depth must be at least 2");
  end

  localparam logic [AddrW-1:0] LastAddr = AddrW'(Depth - 1);

  logic [1:0]       state_q, state_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic             pipe_vld_q;
  logic [AddrW-1:0] pipe_idx_q;
  logic             clear;
  logic [MuW-1:0]   mu;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    clear   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRead;
          addr_d  = '0;
          clear   = 1'b1;
        end
      end
      StRead: begin
        if (addr_q == LastAddr) state_d = StDrain;
        else                    addr_d  = addr_q + 1'b1;
      end
      StDrain: state_d = StDone;
      StDone:  if (out_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // pipe_vld_q/pipe_idx_q mark the cycle in which rd_data_i carries the word for pipe_idx_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      pipe_vld_q <= 1'b0;
      pipe_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pipe_vld_q <= (state_q == StRead);
      pipe_idx_q <= addr_q;
    end
  end

  assign mu = MuW'(mu_extract(64'(rd_data_i), MuW));

  outmf_mac #(
    .AddrW (AddrW),
    .MuW   (MuW),
    .AccW  (AccW)
  ) u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (clear),
    .valid_i   (pipe_vld_q),
    .idx_i     (pipe_idx_q),
    .mu_i      (mu),
    .num_o     (num_o),
    .den_o     (den_o)
`ifdef OUTMF_MAX_EN
    ,
    .max_mu_o  (max_mu_o),
    .max_idx_o (max_idx_o)
`endif
  );

  assign busy_o      = (state_q != StIdle);
  assign rd_en_o     = (state_q == StRead);
  assign rd_addr_o   = addr_q;
  assign out_valid_o = (state_q == StDone);
  assign den_zero_o  = out_valid_o && (den_o == '0);

endmodule

// File: tb/tb_outmf_cog_acc.sv
// Self-checking bench for outmf_cog_acc: behavioural RAM, arithmetic reference model and
// randomized tables. Define OUTMF_MAX_EN to also exercise the max tracker.
module tb_outmf_cog_acc;

  localparam int Depth = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] num;
  logic [31:0] den;
  logic        den_zero;
`ifdef OUTMF_MAX_EN
  logic [15:0] max_mu;
  logic [4:0]  max_idx;
`endif

  logic [31:0] mem [Depth];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  // Port-B RAM: one-cycle read latency, no output register.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  outmf_cog_acc u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .busy_o      (busy),
    .rd_en_o     (rd_en),
    .rd_addr_o   (rd_addr),
    .rd_data_i   (rd_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .num_o       (num),
    .den_o       (den),
    .den_zero_o  (den_zero)
`ifdef OUTMF_MAX_EN
    ,
    .max_mu_o    (max_mu),
    .max_idx_o   (max_idx)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected CoG sums and first-occurrence maximum of the current table.
  function automatic void model(output logic [31:0] e_num, output logic [31:0] e_den,
                                output logic [15:0] e_max, output logic [4:0] e_idx);
    longint n = 0, d = 0;
    int m = 0, mi = 0;
    for (int i = 0; i < Depth; i++) begin
      int v = int'(mem[i][15:0]);
      n += longint'(v) * i;
      d += v;
      if (v > m) begin m = v; mi = i; end
    end
    e_num = n[31:0];
    e_den = d[31:0];
    e_max = m[15:0];
    e_idx = mi[4:0];
  endfunction

  // Pulses start and waits for out_valid; lat counts edges after the accepting edge.
  task automatic do_sweep(output int lat, output int rd_cnt, output bit seq_ok);
    int exp_addr = 0;
    lat = 0; rd_cnt = 0; seq_ok = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    while (1) begin
      if (rd_en === 1'b1) begin
        if (rd_addr !== 5'(exp_addr)) seq_ok = 1'b0;
        exp_addr++;
        rd_cnt++;
      end
      if (out_valid === 1'b1 || lat >= 100) break;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
    checks++; if (rd_addr !== 5'd0) begin fails++; $display("FAIL reset_addr: got %0d want 0", rd_addr); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (num !== 32'd0 || den !== 32'd0) begin fails++; $display("FAIL reset_acc: got num %0d den %0d want 0 0", num, den); end
    checks++; if (den_zero !== 1'b0) begin fails++; $display("FAIL reset_den_zero: got %b want 0", den_zero); end
    rst_n = 1'b1;
    step();
  endtask

  // Runs one sweep on the current table with out_ready high and checks everything.
  task automatic run_and_check(input string name);
    logic [31:0] e_num, e_den;
    logic [15:0] e_max;
    logic [4:0]  e_idx;
    int lat, rd_cnt;
    bit seq_ok;
    model(e_num, e_den, e_max, e_idx);
    out_ready = 1'b1;
    do_sweep(lat, rd_cnt, seq_ok);
    checks++; if (lat != Depth + 1) begin fails++; $display("FAIL %s_latency: got %0d want %0d", name, lat, Depth + 1); end
    checks++; if (rd_cnt != Depth || !seq_ok) begin fails++; $display("FAIL %s_reads: got %0d reads (order ok %0d) want %0d", name, rd_cnt, seq_ok, Depth); end
    checks++; if (num !== e_num) begin fails++; $display("FAIL %s_num: got %0d want %0d", name, num, e_num); end
    checks++; if (den !== e_den) begin fails++; $display("FAIL %s_den: got %0d want %0d", name, den, e_den); end
    checks++; if (den_zero !== (e_den == 0)) begin fails++; $display("FAIL %s_den_zero: got %b want %b", name, den_zero, e_den == 0); end
`ifdef OUTMF_MAX_EN
    checks++; if (max_mu !== e_max || max_idx !== e_idx) begin fails++; $display("FAIL %s_max: got %0d@%0d want %0d@%0d", name, max_mu, max_idx, e_max, e_idx); end
`endif
    step();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL %s_release: got busy %b valid %b want 0 0", name, busy, out_valid); end
    checks++; if (num !== e_num || den !== e_den) begin fails++; $display("FAIL %s_hold_after: got %0d/%0d want %0d/%0d", name, num, den, e_num, e_den); end
    out_ready = 1'b0;
    step();
  endtask

  task automatic test_ones();
    for (int i = 0; i < Depth; i++) mem[i] = 32'd1;
    run_and_check("ones");
    checks++; if (num !== 32'd496 || den !== 32'd32) begin fails++; $display("FAIL ones_const: got %0d/%0d want 496/32", num, den); end
  endtask

  task automatic test_ramp();
    for (int i = 0; i < Depth; i++) mem[i] = {16'hFFFF, 16'(i)};
    run_and_check("ramp");
    checks++; if (num !== 32'd10416 || den !== 32'd496) begin fails++; $display("FAIL ramp_const: got %0d/%0d want 10416/496", num, den); end
  endtask

  task automatic test_zero();
    for (int i = 0; i < Depth; i++) mem[i] = {16'($urandom), 16'd0};
    run_and_check("zero");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < Depth; i++) mem[i] = $urandom;
      if (r == 3) mem[$urandom_range(0, Depth - 1)] = 32'h0000FFFF;
      run_and_check("random");
    end
  endtask

  task automatic test_stall();
    logic [31:0] e_num, e_den;
    logic [15:0] e_max;
    logic [4:0]  e_idx;
    int lat, rd_cnt;
    bit seq_ok, stable, quiet;
    for (int i = 0; i < Depth; i++) mem[i] = $urandom;
    model(e_num, e_den, e_max, e_idx);
    out_ready = 1'b0;
    do_sweep(lat, rd_cnt, seq_ok);
    checks++; if (lat != Depth + 1) begin fails++; $display("FAIL stall_latency: got %0d want %0d", lat, Depth + 1); end
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      if (out_valid !== 1'b1 || busy !== 1'b1 || num !== e_num || den !== e_den || rd_en !== 1'b0)
        stable = 1'b0;
      step();
      start = 1'b0;
    end
    checks++; if (!stable) begin fails++; $display("FAIL stall_hold: got valid %b busy %b num %0d den %0d want 1 1 %0d %0d", out_valid, busy, num, den, e_num, e_den); end
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL stall_handshake: got busy %b valid %b want 0 0", busy, out_valid); end
    quiet = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (rd_en !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      step();
    end
    checks++; if (!quiet) begin fails++; $display("FAIL stall_no_restart: got rd_en %b valid %b busy %b want idle", rd_en, out_valid, busy); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    int lat, rd_cnt;
    bit seq_ok;
    for (int i = 0; i < Depth; i++) mem[i] = $urandom;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || rd_en !== 1'b0 || out_valid !== 1'b0 || rd_addr !== 5'd0) begin fails++; $display("FAIL abort_ctrl: got busy %b rd_en %b valid %b addr %0d want 0", busy, rd_en, out_valid, rd_addr); end
    checks++; if (num !== 32'd0 || den !== 32'd0 || den_zero !== 1'b0) begin fails++; $display("FAIL abort_acc: got %0d/%0d dz %b want 0/0 0", num, den, den_zero); end
    repeat (2) step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < Depth; i++) mem[i] = 32'd2;
    out_ready = 1'b1;
    do_sweep(lat, rd_cnt, seq_ok);
    checks++; if (lat != Depth + 1) begin fails++; $display("FAIL abort_latency: got %0d want %0d", lat, Depth + 1); end
    checks++; if (num !== 32'd992 || den !== 32'd64) begin fails++; $display("FAIL abort_result: got %0d/%0d want 992/64", num, den); end
    step();
    out_ready = 1'b0;
  endtask

`ifdef OUTMF_MAX_EN
  task automatic test_max_tie();
    for (int i = 0; i < Depth; i++) mem[i] = 32'd5;
    mem[7]  = 32'd100;
    mem[20] = 32'd100;
    run_and_check("max_tie");
    checks++; if (num !== 32'd5045 || den !== 32'd350) begin fails++; $display("FAIL max_tie_const: got %0d/%0d want 5045/350", num, den); end
    checks++; if (max_mu !== 16'd100 || max_idx !== 5'd7) begin fails++; $display("FAIL max_tie_const_max: got %0d@%0d want 100@7", max_mu, max_idx); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ones();
    test_ramp();
    test_zero();
    test_random();
    test_stall();
    test_reset_abort();
`ifdef OUTMF_MAX_EN
    test_max_tie();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
